// File: rtl/cdb_arbiter_pkg.sv
// cdb_pkg: shared widths and the result record carried from a functional
// unit through its holding buffer onto the common data bus.
package cdb_pkg;

   localparam int CDB_NUM_REQ = 4;   // default number of writeback ports
   localparam int DATA_W      = 32;  // result width
   localparam int ROB_IDX_W   = 5;   // 32-entry reorder buffer
   localparam int REG_W       = 5;   // architectural register index

   // One writeback result as it sits in a buffer or on the CDB.
   typedef struct packed {
      logic [DATA_W-1:0]    data;
      logic [REG_W-1:0]     rd_addr;
      logic [ROB_IDX_W-1:0] rob_idx;
   } cdb_req_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: writeback request side plus CDB broadcast side.
// master = functional units / consumers, slave = the arbiter.
interface cdb_arbiter_if
   import cdb_pkg::*;
#(
   parameter int NUM_REQ = CDB_NUM_REQ
);

   logic [NUM_REQ-1:0]                req_valid_i;
   logic [NUM_REQ-1:0]                req_ready_o;
   logic [NUM_REQ-1:0][DATA_W-1:0]    req_data_i;
   logic [NUM_REQ-1:0][REG_W-1:0]     req_rd_addr_i;
   logic [NUM_REQ-1:0][ROB_IDX_W-1:0] req_rob_idx_i;
   logic                              flush_i;

   logic                              cdb_valid_o;
   logic [DATA_W-1:0]                 cdb_data_o;
   logic [REG_W-1:0]                  cdb_rd_addr_o;
   logic [ROB_IDX_W-1:0]              cdb_rob_idx_o;
   logic [NUM_REQ-1:0]                grant_o;

   modport slave (
      input  req_valid_i, req_data_i, req_rd_addr_i, req_rob_idx_i, flush_i,
      output req_ready_o, cdb_valid_o, cdb_data_o, cdb_rd_addr_o,
             cdb_rob_idx_o, grant_o
   );

   modport master (
      output req_valid_i, req_data_i, req_rd_addr_i, req_rob_idx_i, flush_i,
      input  req_ready_o, cdb_valid_o, cdb_data_o, cdb_rd_addr_o,
             cdb_rob_idx_o, grant_o
   );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker: purely combinational round-robin pick. Scans req starting at
// ptr, wrapping modulo N, and returns the first set bit as one-hot + index.
module rr_picker #(
   parameter  int N     = 4,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx
);

   logic found;
   int   cand;

   // First requester at or after ptr, in circular order.
   always_comb begin
      // NOTE: every output gets a default before the loop, so no path leaves a latch.
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int off = 0; off < N; off++) begin
         cand = (int'(ptr) + off) % N;
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one-entry holding buffer per functional unit, round-robin
// grant of one buffered result per cycle onto a registered CDB; flush drops
// everything pending. Define CDB_ARB_BYPASS_EN to let a request go straight
// to the CDB register when every buffer is empty (latency 1 instead of 2).
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_REQ = CDB_NUM_REQ
) (
   input  logic         clk,
   input  logic         rst_n,
   cdb_arbiter_if.slave bus
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] buf_valid;
   cdb_req_t           buf_q  [NUM_REQ];
   cdb_req_t           in_req [NUM_REQ];
   logic [PTR_W-1:0]   rr_ptr;
   cdb_req_t           cdb_q;
   logic               cdb_valid;

   logic [NUM_REQ-1:0] pick_grant, grant, ready, load, byp_sel;
   logic [PTR_W-1:0]   pick_idx, byp_idx;
   logic               byp_valid;

   // Pointer value just past slot k, wrapping from NUM_REQ-1 to 0.
   function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] k);
      return (k == PTR_W'(NUM_REQ - 1)) ? '0 : k + PTR_W'(1);
   endfunction

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_in
      assign in_req[i] = '{data:    bus.req_data_i[i],
                           rd_addr: bus.req_rd_addr_i[i],
                           rob_idx: bus.req_rob_idx_i[i]};
   end

   rr_picker #(.N(NUM_REQ)) u_pick (
      .req  (buf_valid),
      .ptr  (rr_ptr),
      .grant(pick_grant),
      .idx  (pick_idx)
   );

   // Flush suppresses both the grant and acceptance of new results.
   assign grant = bus.flush_i ? '0 : pick_grant;
   assign ready = {NUM_REQ{!bus.flush_i}} & (~buf_valid | grant);

`ifdef CDB_ARB_BYPASS_EN
   logic [NUM_REQ-1:0] byp_pick;

   rr_picker #(.N(NUM_REQ)) u_byp (
      .req  (bus.req_valid_i),
      .ptr  (rr_ptr),
      .grant(byp_pick),
      .idx  (byp_idx)
   );

   assign byp_valid = !bus.flush_i && (buf_valid == '0) && (|bus.req_valid_i);
   assign byp_sel   = byp_valid ? byp_pick : '0;
`else
   assign byp_valid = 1'b0;
   assign byp_idx   = '0;
   assign byp_sel   = '0;
`endif

   // A bypassed request is accepted but never occupies its buffer.
   assign load = ready & bus.req_valid_i & ~byp_sel;

   // Control state: buffer occupancy, round-robin pointer and the CDB register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid <= '0;
         rr_ptr    <= '0;
         cdb_valid <= 1'b0;
         cdb_q     <= '0;
      end else if (bus.flush_i) begin
         buf_valid <= '0;
         cdb_valid <= 1'b0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
         buf_valid <= (buf_valid & ~grant) | load;
         if (|grant) begin
            rr_ptr    <= ptr_after(pick_idx);
            cdb_valid <= 1'b1;
            cdb_q     <= buf_q[pick_idx];
         end else if (byp_valid) begin
            rr_ptr    <= ptr_after(byp_idx);
            cdb_valid <= 1'b1;
            cdb_q     <= in_req[byp_idx];
         end else begin
            cdb_valid <= 1'b0;
         end
      end
   end

   // Buffer payloads capture an accepted result; a granted slot may refill on the same edge.
   always_ff @(posedge clk) begin
      // NOTE: payload registers have no reset; buf_valid alone says whether they hold anything.
      for (int i = 0; i < NUM_REQ; i++) begin
         if (load[i]) buf_q[i] <= in_req[i];
      end
   end

   assign bus.req_ready_o   = ready;
   assign bus.grant_o       = grant;
   assign bus.cdb_valid_o   = cdb_valid;
   assign bus.cdb_data_o    = cdb_q.data;
   assign bus.cdb_rd_addr_o = cdb_q.rd_addr;
   assign bus.cdb_rob_idx_o = cdb_q.rob_idx;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven per-cycle vectors for ready/grant/CDB tag,
// a scoreboard of accepted results matched against every CDB broadcast,
// and hand-written single-request and asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_cdb_arbiter;
   import cdb_pkg::*;

   localparam int N = 4;

   logic clk;
   logic rst_n;

   cdb_arbiter_if #(.NUM_REQ(N)) bus ();

   cdb_arbiter #(.NUM_REQ(N)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct packed {
      logic            rst_before;
      logic [3:0]      rv;
      logic [3:0][4:0] tags;
      logic            flush;
      logic [3:0]      ready;
      logic [3:0]      grant;
      logic            cdb_v;
      logic [4:0]      cdb_tag;
   } vec_t;

   typedef struct packed {
      logic [1:0] unit;
      cdb_req_t   rec;
   } sb_t;

   vec_t tbl [$];
   sb_t  sb_q [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk_vec(input logic rb, input logic [3:0] rv, input logic [19:0] tags,
                                   input logic fl, input logic [3:0] rdy, input logic [3:0] gnt,
                                   input logic cv, input logic [4:0] ct);
      vec_t v;
      v.rst_before = rb;
      v.rv         = rv;
      v.tags       = tags;
      v.flush      = fl;
      v.ready      = rdy;
      v.grant      = gnt;
      v.cdb_v      = cv;
      v.cdb_tag    = ct;
      return v;
   endfunction

   // Result record for unit u carrying tag t (tag doubles as ROB index).
   function automatic cdb_req_t mk_rec(input int u, input logic [4:0] t);
      cdb_req_t r;
      r.data    = {8'h5A, 8'(u), 11'h0, t};
      r.rd_addr = 5'(8 + u);
      r.rob_idx = t;
      return r;
   endfunction

   // Every CDB broadcast must match the oldest pending result of some unit.
   always @(negedge clk) begin : monitor
      cdb_req_t obs;
      int       hit;
      logic     order_ok;
      if (rst_n && bus.cdb_valid_o) begin
         obs.data    = bus.cdb_data_o;
         obs.rd_addr = bus.cdb_rd_addr_o;
         obs.rob_idx = bus.cdb_rob_idx_o;
         hit = -1;
         foreach (sb_q[j]) if (hit < 0 && sb_q[j].rec == obs) hit = j;
         n_cmp++;
         if (hit < 0) begin
            n_bad++;
            $display("FAIL sb_match: got data=%h rd=%0d idx=%0d, required a pending accepted result",
                     obs.data, obs.rd_addr, obs.rob_idx);
         end else begin
            order_ok = 1'b1;
            for (int j = 0; j < hit; j++) if (sb_q[j].unit == sb_q[hit].unit) order_ok = 1'b0;
            check("sb_order", 64'(order_ok), 64'(1));
            sb_q.delete(hit);
         end
      end
   end

   task automatic clear_inputs();
      bus.req_valid_i   = '0;
      bus.flush_i       = 1'b0;
      bus.req_data_i    = '0;
      bus.req_rd_addr_i = '0;
      bus.req_rob_idx_i = '0;
   endtask

   // Reset pulse placed between clock edges; outputs must clear without a clock.
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      clear_inputs();
      #1;
      check("rst_cdb_valid", 64'(bus.cdb_valid_o), 64'(0));
      check("rst_cdb_data", 64'(bus.cdb_data_o), 64'(0));
      check("rst_cdb_rd", 64'(bus.cdb_rd_addr_o), 64'(0));
      check("rst_cdb_idx", 64'(bus.cdb_rob_idx_o), 64'(0));
      check("rst_grant", 64'(bus.grant_o), 64'(0));
      sb_q.delete();
      #1;
      rst_n = 1'b1;
      #1;
      check("rst_ready", 64'(bus.req_ready_o), 64'hF);
   endtask

   task automatic run_vec(input vec_t v, input int k);
      cdb_req_t r;
      if (v.rst_before) do_reset();
      bus.flush_i     = v.flush;
      bus.req_valid_i = v.rv;
      for (int u = 0; u < N; u++) begin
         r = mk_rec(u, v.tags[u]);
         bus.req_data_i[u]    = r.data;
         bus.req_rd_addr_i[u] = r.rd_addr;
         bus.req_rob_idx_i[u] = r.rob_idx;
         if (v.rv[u] && v.ready[u]) sb_q.push_back('{unit: 2'(u), rec: r});
      end
      #1;
      check($sformatf("v%0d_ready", k), 64'(bus.req_ready_o), 64'(v.ready));
      check($sformatf("v%0d_grant", k), 64'(bus.grant_o), 64'(v.grant));
      @(posedge clk);
      #1;
      if (v.flush) sb_q.delete();
      check($sformatf("v%0d_cdb_valid", k), 64'(bus.cdb_valid_o), 64'(v.cdb_v));
      if (v.cdb_v) check($sformatf("v%0d_cdb_tag", k), 64'(bus.cdb_rob_idx_o), 64'(v.cdb_tag));
   endtask

   // Unit 2 alone: visible on the CDB after the second edge, for one cycle.
   task automatic single_req(input string nm);
      cdb_req_t r;
      r = '{data: 32'hDEADBEEF, rd_addr: 5'd5, rob_idx: 5'd7};
      clear_inputs();
      bus.req_valid_i      = 4'b0100;
      bus.req_data_i[2]    = r.data;
      bus.req_rd_addr_i[2] = r.rd_addr;
      bus.req_rob_idx_i[2] = r.rob_idx;
      sb_q.push_back('{unit: 2'd2, rec: r});
      #1;
      check({nm, "_ready"}, 64'(bus.req_ready_o), 64'hF);
      @(posedge clk);
      #1;
      bus.req_valid_i = '0;
      check({nm, "_early_valid"}, 64'(bus.cdb_valid_o), 64'(0));
      #1;
      check({nm, "_grant"}, 64'(bus.grant_o), 64'(4'b0100));
      @(posedge clk);
      #1;
      check({nm, "_valid"}, 64'(bus.cdb_valid_o), 64'(1));
      check({nm, "_data"}, 64'(bus.cdb_data_o), 64'(32'hDEADBEEF));
      check({nm, "_rd"}, 64'(bus.cdb_rd_addr_o), 64'(5));
      check({nm, "_idx"}, 64'(bus.cdb_rob_idx_o), 64'(7));
      @(posedge clk);
      #1;
      check({nm, "_valid_drop"}, 64'(bus.cdb_valid_o), 64'(0));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation still running at time limit, required completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst_n = 1'b0;
      clear_inputs();

      // All four simultaneously, rr_ptr=0: units 0..3 in order, pointer back at 0.
      tbl.push_back(mk_vec(1, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 0, 4'b1111, 4'b0000, 0, 0));
      tbl.push_back(mk_vec(0, 4'b0000, 20'd0, 0, 4'b0001, 4'b0001, 1, 1));
      tbl.push_back(mk_vec(0, 4'b0000, 20'd0, 0, 4'b0011, 4'b0010, 1, 2));
      tbl.push_back(mk_vec(0, 4'b0000, 20'd0, 0, 4'b0111, 4'b0100, 1, 3));
      tbl.push_back(mk_vec(0, 4'b0000, 20'd0, 0, 4'b1111, 4'b1000, 1, 4));
      tbl.push_back(mk_vec(0, 4'b0000, 20'd0, 0, 4'b1111, 4'b0000, 0, 0));
      tbl.push_back(mk_vec(0, 4'b0011, {5'd0, 5'd0, 5'd6, 5'd5}, 0, 4'b1111, 4'b0000, 0, 0));
      tbl.push_back(mk_vec(0, 4'b0000, 20'd0, 0, 4'b1101, 4'b0001, 1, 5));
      tbl.push_back(mk_vec(0, 4'b0000, 20'd0, 0, 4'b1111, 4'b0010, 1, 6));
      tbl.push_back(mk_vec(0, 4'b0000, 20'd0, 0, 4'b1111, 4'b0000, 0, 0));
      // Unit 1 back-to-back against unit 3: alternation, refill on grant, stall when not granted.
      tbl.push_back(mk_vec(1, 4'b1010, {5'd2, 5'd0, 5'd1, 5'd0}, 0, 4'b1111, 4'b0000, 0, 0));
      tbl.push_back(mk_vec(0, 4'b0010, {5'd0, 5'd0, 5'd3, 5'd0}, 0, 4'b0111, 4'b0010, 1, 1));
      tbl.push_back(mk_vec(0, 4'b0010, {5'd0, 5'd0, 5'd4, 5'd0}, 0, 4'b1101, 4'b1000, 1, 2));
      tbl.push_back(mk_vec(0, 4'b1010, {5'd5, 5'd0, 5'd4, 5'd0}, 0, 4'b1111, 4'b0010, 1, 3));
      tbl.push_back(mk_vec(0, 4'b0000, 20'd0, 0, 4'b1101, 4'b1000, 1, 5));
      tbl.push_back(mk_vec(0, 4'b0000, 20'd0, 0, 4'b1111, 4'b0010, 1, 4));
      tbl.push_back(mk_vec(0, 4'b0000, 20'd0, 0, 4'b1111, 4'b0000, 0, 0));
      // Flush with three buffers full: nothing accepted, nothing leaks, rr_ptr held at 1.
      tbl.push_back(mk_vec(1, 4'b0111, {5'd0, 5'd3, 5'd2, 5'd1}, 0, 4'b1111, 4'b0000, 0, 0));
      tbl.push_back(mk_vec(0, 4'b1000, {5'd4, 5'd0, 5'd0, 5'd0}, 0, 4'b1001, 4'b0001, 1, 1));
      tbl.push_back(mk_vec(0, 4'b1000, {5'd9, 5'd0, 5'd0, 5'd0}, 1, 4'b0000, 4'b0000, 0, 0));
      tbl.push_back(mk_vec(0, 4'b0000, 20'd0, 0, 4'b1111, 4'b0000, 0, 0));
      tbl.push_back(mk_vec(0, 4'b0000, 20'd0, 0, 4'b1111, 4'b0000, 0, 0));
      tbl.push_back(mk_vec(0, 4'b1001, {5'd7, 5'd0, 5'd0, 5'd6}, 0, 4'b1111, 4'b0000, 0, 0));
      tbl.push_back(mk_vec(0, 4'b0000, 20'd0, 0, 4'b1110, 4'b1000, 1, 7));
      tbl.push_back(mk_vec(0, 4'b0000, 20'd0, 0, 4'b1111, 4'b0001, 1, 6));
      tbl.push_back(mk_vec(0, 4'b0000, 20'd0, 0, 4'b1111, 4'b0000, 0, 0));

      repeat (2) @(posedge clk);
      do_reset();
      check("idle_cdb_valid", 64'(bus.cdb_valid_o), 64'(0));
      single_req("single");

      foreach (tbl[k]) run_vec(tbl[k], k);

      // Mid-operation asynchronous reset with all buffers full and the CDB busy.
      do_reset();
      bus.req_valid_i = 4'b1111;
      for (int u = 0; u < N; u++) begin
         cdb_req_t r;
         r = mk_rec(u, 5'(20 + u));
         bus.req_data_i[u]    = r.data;
         bus.req_rd_addr_i[u] = r.rd_addr;
         bus.req_rob_idx_i[u] = r.rob_idx;
         sb_q.push_back('{unit: 2'(u), rec: r});
      end
      @(posedge clk);
      #1;
      bus.req_valid_i = '0;
      @(posedge clk);
      #1;
      check("pre_rst_cdb_valid", 64'(bus.cdb_valid_o), 64'(1));
      check("pre_rst_cdb_idx", 64'(bus.cdb_rob_idx_o), 64'(20));
      do_reset();
      single_req("after_rst");

      repeat (2) @(posedge clk);
      #1;
      check("sb_drain", 64'(sb_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
